// File: rtl/i2c_slave_regif.sv
// I2C target that turns device-address / register-pointer / data transfers into
// parallel register-bank writes and combinational reads, oversampling SCL/SDA in clk.
module i2c_slave_regif #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_DEV_ADDR = 4'd1;
  localparam logic [3:0] S_DEV_ACK  = 4'd2;
  localparam logic [3:0] S_REG_ADDR = 4'd3;
  localparam logic [3:0] S_REG_ACK  = 4'd4;
  localparam logic [3:0] S_WR_DATA  = 4'd5;
  localparam logic [3:0] S_WR_ACK   = 4'd6;
  localparam logic [3:0] S_RD_DATA  = 4'd7;
  localparam logic [3:0] S_RD_ACK   = 4'd8;
  localparam logic [3:0] S_IGNORE   = 4'd9;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  logic [3:0] state_q,   state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q,   shift_d;
  logic [7:0] ptr_q,     ptr_d;
  logic       rw_q,      rw_d;
  logic       sda_oe_q,  sda_oe_d;
  logic       busy_q,    busy_d;
  logic       wr_en_q,   wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] rx_byte;

  // Synchronisers preset to the idle bus level so reset never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  =  scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s &  scl_prev_q;
  assign start_det =  scl_s &  scl_prev_q &  sda_prev_q & ~sda_s;
  assign stop_det  =  scl_s &  scl_prev_q & ~sda_prev_q &  sda_s;
  assign rx_byte   = {shift_q[6:0], sda_s};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (start_det) begin
      state_d   = S_DEV_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = S_IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        S_DEV_ADDR, S_REG_ADDR, S_WR_DATA: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (state_q == S_DEV_ADDR) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state_d = S_DEV_ACK;
                  busy_d  = 1'b1;
                  rw_d    = rx_byte[0];
                end else begin
                  state_d = S_IGNORE;
                  busy_d  = 1'b0;
                end
              end else if (state_q == S_REG_ADDR) begin
                ptr_d   = rx_byte;
                state_d = S_REG_ACK;
              end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = rx_byte;
                ptr_d     = ptr_q + 8'd1;
                state_d   = S_WR_ACK;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        // bit_cnt tracks the ACK clock: 0 = await fall, 1 = await 9th rise, 2 = await final fall.
        S_DEV_ACK, S_REG_ACK, S_WR_ACK: begin
          if (scl_fall && bit_cnt_q == 4'd0) begin
            sda_oe_d  = 1'b1;
            bit_cnt_d = 4'd1;
          end else if (scl_rise && bit_cnt_q == 4'd1) begin
            bit_cnt_d = 4'd2;
          end else if (scl_fall && bit_cnt_q == 4'd2) begin
            bit_cnt_d = 4'd0;
            if (state_q == S_DEV_ACK && rw_q) begin
              shift_d  = rd_data;
              sda_oe_d = ~rd_data[7];
              state_d  = S_RD_DATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = (state_q == S_DEV_ACK) ? S_REG_ADDR : S_WR_DATA;
            end
          end
        end

        S_RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = S_RD_ACK;
            end else begin
              sda_oe_d  = ~shift_q[6];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        // Pointer advances on the master ACK so rd_addr is settled before the reload fall.
        S_RD_ACK: begin
          if (scl_rise && bit_cnt_q == 4'd0) begin
            if (sda_s) begin
              state_d = S_IGNORE;
              busy_d  = 1'b0;
            end else begin
              ptr_d     = ptr_q + 8'd1;
              bit_cnt_d = 4'd1;
            end
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            shift_d   = rd_data;
            sda_oe_d  = ~rd_data[7];
            bit_cnt_d = 4'd0;
            state_d   = S_RD_DATA;
          end
        end

        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'd0;
      ptr_q     <= 8'd0;
      rw_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 8'd0;
      wr_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign sda_oe  = sda_oe_q;
  assign busy    = busy_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_addr = ptr_q;

endmodule
